// File: rtl/decode_scoreboard_if.sv
// Decode/writeback handshake bundle between the pipeline and the decode scoreboard.
interface decode_scoreboard_if #(
    parameter int unsigned LAT_W = 3,
    parameter int unsigned IDX_W = 5
);
    logic             id_valid;
    logic [IDX_W-1:0] id_r1;
    logic [IDX_W-1:0] id_r2;
    logic             id_use_r1;
    logic             id_use_r2;
    logic             id_branch;
    logic [IDX_W-1:0] id_rd;
    logic [LAT_W-1:0] id_lat;
    logic             flush;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_rd;
    logic             stall;
    logic             issue;

    // Pipeline side: presents the decode slot and writeback, receives stall/issue.
    modport master (
        output id_valid, id_r1, id_r2, id_use_r1, id_use_r2, id_branch,
               id_rd, id_lat, flush, wb_valid, wb_rd,
        input  stall, issue
    );

    // Scoreboard side.
    modport slave (
        input  id_valid, id_r1, id_r2, id_use_r1, id_use_r2, id_branch,
               id_rd, id_lat, flush, wb_valid, wb_rd,
        output stall, issue
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Register scoreboard and stall controller for the MIPS decode stage.
// Tracks outstanding GPR writes (pending bit + forwardable countdown) and
// stalls decode on RAW hazards; ID-stage branches wait for writeback.
// Optional feature macro: DECODE_SB_STATS_EN adds stall_cycles/branch_stalls counters.
module decode_scoreboard #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned LAT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_scoreboard_if.slave   sb,
    output logic [NREG-1:0]      pend_mask
`ifdef DECODE_SB_STATS_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          branch_stalls
`endif
);

    localparam int unsigned IDX_W = $clog2(NREG);

    logic [NREG-1:0]  pend;
    logic [LAT_W-1:0] cnt [NREG];

    logic wb_hit_r1;
    logic wb_hit_r2;
    logic haz_r1;
    logic haz_r2;
    logic stall_c;
    logic issue_c;

    // Source hazard detection; a same-cycle writeback resolves it (write-first register file).
    always_comb begin
        wb_hit_r1 = 1'b0;
        wb_hit_r2 = 1'b0;
        haz_r1    = 1'b0;
        haz_r2    = 1'b0;
        wb_hit_r1 = sb.wb_valid && (sb.wb_rd == sb.id_r1);
        wb_hit_r2 = sb.wb_valid && (sb.wb_rd == sb.id_r2);
        if (sb.id_use_r1 && (sb.id_r1 != IDX_W'(0)) && pend[sb.id_r1] && !wb_hit_r1)
            haz_r1 = sb.id_branch || (cnt[sb.id_r1] != LAT_W'(0));
        if (sb.id_use_r2 && (sb.id_r2 != IDX_W'(0)) && pend[sb.id_r2] && !wb_hit_r2)
            haz_r2 = sb.id_branch || (cnt[sb.id_r2] != LAT_W'(0));
    end

    // Stall/issue decision; both forced low while reset is asserted.
    always_comb begin
        stall_c = 1'b0;
        issue_c = 1'b0;
        stall_c = rst_n && sb.id_valid && !sb.flush && (haz_r1 || haz_r2);
        issue_c = rst_n && sb.id_valid && !sb.flush && !stall_c;
    end

    assign sb.stall = stall_c;
    assign sb.issue = issue_c;

    // Per-register tracking: new issue owns the register, else writeback clears, else count down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < int'(NREG); i++) begin
                if (issue_c && (sb.id_rd == IDX_W'(i))) begin
                    pend[i] <= 1'b1;
                    cnt[i]  <= sb.id_lat;
                end else if (sb.wb_valid && (sb.wb_rd == IDX_W'(i))) begin
                    pend[i] <= 1'b0;
                    cnt[i]  <= '0;
                end else if (cnt[i] != LAT_W'(0)) begin
                    cnt[i]  <= cnt[i] - LAT_W'(1);
                end
            end
        end
    end

    // Register 0 is hard-wired zero and never reported pending.
    always_comb begin
        pend_mask    = pend;
        pend_mask[0] = 1'b0;
    end

`ifdef DECODE_SB_STATS_EN
    // Saturating stall statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            branch_stalls <= '0;
        end else begin
            if (stall_c && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (stall_c && sb.id_branch && (branch_stalls != 32'hFFFF_FFFF))
                branch_stalls <= branch_stalls + 32'd1;
        end
    end
`endif

endmodule
